// File: rtl/data_mem_responder.sv
// Data-memory responder: byte/half/word load-store on a word RAM, LATENCY+1 edges from accept to access, ready the cycle after.
// Not pipelined: one request at a time, req is only sampled in IDLE, so sustained period is LATENCY+3 cycles.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clka,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state, state_next;
    logic [3:0]            cnt;
    logic                  we_q, lu_q, ill_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  ill;
    logic                  access;
    logic [ADDR_WIDTH-1:0] widx;
    logic [1:0]            off;
    logic [31:0]           word;
    logic [31:0]           load_val;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [3:0]            be;
    logic [31:0]           wd;

    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Legality is judged on the live request fields and frozen at accept.
    always_comb begin
        ill = (size == 2'b11)
           || (size == 2'b01 && addr[0])
           || (size == 2'b10 && addr[1:0] != 2'b00)
           || (addr[31:ADDR_WIDTH+2] != '0);
    end

    assign access = (state == WAIT) && (cnt == 4'd0);
    assign widx   = addr_q[ADDR_WIDTH+1:2];
    assign off    = addr_q[1:0];
    assign word   = mem[widx];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = WAIT;
            WAIT:    if (cnt == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        lane_b   = word[{off, 3'b000} +: 8];
        lane_h   = off[1] ? word[31:16] : word[15:0];
        load_val = word;
        case (size_q)
            2'b00:   load_val = lu_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_val = lu_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_val = word;
        endcase
    end

    // Store data is replicated across lanes; the byte enables pick the target lanes.
    always_comb begin
        be = 4'b1111;
        wd = wdata_q;
        case (size_q)
            2'b00: begin
                be = 4'b0001 << off;
                wd = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be = off[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_q[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ready   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            rdata   <= 32'h0;
            we_q    <= 1'b0;
            lu_q    <= 1'b0;
            ill_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            ready <= access;
            err   <= access && ill_q;
            if (state == IDLE && req) begin
                we_q    <= we;
                lu_q    <= load_unsigned;
                ill_q   <= ill;
                size_q  <= size;
                addr_q  <= addr[ADDR_WIDTH+1:0];
                wdata_q <= wdata;
                cnt     <= 4'(LATENCY);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                if (ill_q)
                    rdata <= 32'h0;
                else if (!we_q)
                    rdata <= load_val;
            end
        end
    end

    // RAM is deliberately not reset; an async reset returns state to IDLE so no write can follow.
    always_ff @(posedge clka) begin
        if (access && we_q && !ill_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed table-driven bench for data_mem_responder; a second instance with LATENCY=0 covers the zero-wait throughput case.
module tb_data_mem_responder;
    localparam int LAT = 2;

    logic        clka = 1'b0;
    logic        rst;
    logic        req, req0, we, load_unsigned;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        ready, err, busy;
    logic [31:0] rdata;
    logic        ready0, err0, busy0;
    logic [31:0] rdata0;

    int tests = 0;
    int fails = 0;

    always #5 clka = ~clka;

    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
        .clka(clka), .rst(rst), .req(req), .we(we), .size(size),
        .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata), .err(err), .busy(busy)
    );

    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dut0 (
        .clka(clka), .rst(rst), .req(req0), .we(we), .size(size),
        .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata),
        .ready(ready0), .rdata(rdata0), .err(err0), .busy(busy0)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        lu;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];
    vec_t tp[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_fields(input vec_t v);
        we            = v.we;
        size          = v.size;
        load_unsigned = v.lu;
        addr          = v.addr;
        wdata         = v.wdata;
    endtask

    task automatic access(input vec_t v, input string name);
        int n;
        bit seen;
        @(negedge clka);
        set_fields(v);
        req  = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clka);
            n++;
            @(negedge clka);
            if (n == 1) check({name, " busy"}, 32'(busy), 32'd1);
            if (ready) seen = 1'b1;
        end
        req = 1'b0;
        check({name, " latency"}, 32'(n), 32'(LAT + 2));
        check({name, " rdata"}, rdata, v.exp_rdata);
        check({name, " err"}, 32'(err), 32'(v.exp_err));
        @(negedge clka);
        check({name, " ready pulse"}, 32'(ready), 32'd0);
        check({name, " idle"}, 32'(busy), 32'd0);
    endtask

    task automatic tput(input bit sel, input int lat, input string name);
        int cnt, last;
        cnt  = 0;
        last = 0;
        @(negedge clka);
        set_fields(tp[0]);
        if (sel) req0 = 1'b1; else req = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clka);
            if (sel ? ready0 : ready) begin
                if (cnt == 0)
                    check({name, " first ready"}, 32'(c), 32'(lat + 2));
                else
                    check({name, " spacing"}, 32'(c - last), 32'(lat + 3));
                if (cnt > 0 && cnt < 4)
                    check({name, " rdata"}, sel ? rdata0 : rdata, tp[cnt].exp_rdata);
                if (cnt < 4)
                    check({name, " err"}, 32'(sel ? err0 : err), 32'd0);
                last = c;
                cnt++;
                if (cnt < 4) set_fields(tp[cnt]);
                else begin
                    req  = 1'b0;
                    req0 = 1'b0;
                end
            end
        end
        req  = 1'b0;
        req0 = 1'b0;
        check({name, " pulse count"}, 32'(cnt), 32'd4);
    endtask

    initial begin
        // {we, size, lu, addr, wdata, expected rdata, expected err}
        tbl.push_back(vec_t'{1'b1, 2'b10, 1'b0, 32'h10,   32'hDEADBEEF, 32'h00000000, 1'b0});
        tbl.push_back(vec_t'{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0});
        tbl.push_back(vec_t'{1'b1, 2'b10, 1'b0, 32'h10,   32'h11223344, 32'hDEADBEEF, 1'b0});
        tbl.push_back(vec_t'{1'b1, 2'b00, 1'b0, 32'h13,   32'h000000A5, 32'hDEADBEEF, 1'b0});
        tbl.push_back(vec_t'{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hA5223344, 1'b0});
        tbl.push_back(vec_t'{1'b0, 2'b00, 1'b0, 32'h13,   32'h0,        32'hFFFFFFA5, 1'b0});
        tbl.push_back(vec_t'{1'b0, 2'b00, 1'b1, 32'h13,   32'h0,        32'h000000A5, 1'b0});
        tbl.push_back(vec_t'{1'b0, 2'b00, 1'b0, 32'h12,   32'h0,        32'h00000022, 1'b0});
        tbl.push_back(vec_t'{1'b1, 2'b10, 1'b0, 32'h20,   32'h00000000, 32'h00000022, 1'b0});
        tbl.push_back(vec_t'{1'b1, 2'b01, 1'b0, 32'h22,   32'h00008001, 32'h00000022, 1'b0});
        tbl.push_back(vec_t'{1'b0, 2'b10, 1'b0, 32'h20,   32'h0,        32'h80010000, 1'b0});
        tbl.push_back(vec_t'{1'b0, 2'b01, 1'b0, 32'h22,   32'h0,        32'hFFFF8001, 1'b0});
        tbl.push_back(vec_t'{1'b0, 2'b01, 1'b1, 32'h22,   32'h0,        32'h00008001, 1'b0});
        tbl.push_back(vec_t'{1'b0, 2'b01, 1'b0, 32'h20,   32'h0,        32'h00000000, 1'b0});
        tbl.push_back(vec_t'{1'b1, 2'b00, 1'b0, 32'h20,   32'h123456FE, 32'h00000000, 1'b0});
        tbl.push_back(vec_t'{1'b0, 2'b10, 1'b0, 32'h20,   32'h0,        32'h800100FE, 1'b0});
        tbl.push_back(vec_t'{1'b0, 2'b00, 1'b1, 32'h20,   32'h0,        32'h000000FE, 1'b0});
        tbl.push_back(vec_t'{1'b0, 2'b00, 1'b0, 32'h21,   32'h0,        32'h00000000, 1'b0});
        tbl.push_back(vec_t'{1'b0, 2'b10, 1'b0, 32'h12,   32'h0,        32'h00000000, 1'b1});
        tbl.push_back(vec_t'{1'b1, 2'b10, 1'b0, 32'h11,   32'hFFFFFFFF, 32'h00000000, 1'b1});
        tbl.push_back(vec_t'{1'b0, 2'b10, 1'b1, 32'h10,   32'h0,        32'hA5223344, 1'b0});
        tbl.push_back(vec_t'{1'b0, 2'b10, 1'b0, 32'h1000, 32'h0,        32'h00000000, 1'b1});
        tbl.push_back(vec_t'{1'b1, 2'b10, 1'b0, 32'h1010, 32'h00000000, 32'h00000000, 1'b1});
        tbl.push_back(vec_t'{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hA5223344, 1'b0});
        tbl.push_back(vec_t'{1'b0, 2'b11, 1'b0, 32'h10,   32'h0,        32'h00000000, 1'b1});
        tbl.push_back(vec_t'{1'b0, 2'b01, 1'b0, 32'h21,   32'h0,        32'h00000000, 1'b1});
        tbl.push_back(vec_t'{1'b1, 2'b10, 1'b0, 32'h40,   32'hCAFEF00D, 32'h00000000, 1'b0});
        tbl.push_back(vec_t'{1'b0, 2'b10, 1'b0, 32'h40,   32'h0,        32'hCAFEF00D, 1'b0});

        tp.push_back(vec_t'{1'b1, 2'b10, 1'b0, 32'h08,   32'h0102F3F4, 32'h00000000, 1'b0});
        tp.push_back(vec_t'{1'b0, 2'b10, 1'b0, 32'h08,   32'h0,        32'h0102F3F4, 1'b0});
        tp.push_back(vec_t'{1'b0, 2'b00, 1'b0, 32'h08,   32'h0,        32'hFFFFFFF4, 1'b0});
        tp.push_back(vec_t'{1'b0, 2'b01, 1'b1, 32'h0A,   32'h0,        32'h00000102, 1'b0});

        rst = 1'b1;
        req = 1'b0;
        req0 = 1'b0;
        set_fields(tp[0]);
        #12;
        check("reset ready", 32'(ready), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rdata", rdata, 32'h0);
        check("reset busy0", 32'(busy0), 32'd0);
        @(negedge clka);
        rst = 1'b0;

        foreach (tbl[i]) access(tbl[i], $sformatf("v%0d", i));

        // Abort a store during WAIT: outputs clear at once and memory keeps its old word.
        @(negedge clka);
        set_fields(vec_t'{1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, 32'h0, 1'b0});
        req = 1'b1;
        @(posedge clka);
        @(negedge clka);
        check("abort busy before", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort ready", 32'(ready), 32'd0);
        check("abort rdata", rdata, 32'h0);
        req = 1'b0;
        @(negedge clka);
        rst = 1'b0;
        access(vec_t'{1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0}, "after abort");

        tput(1'b0, LAT, "tput lat2");
        tput(1'b1, 0, "tput lat0");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
